mux_2to1: RTL and testbench

//   2-to-1 bit selector for the TRNG entropy path: routes one of two raw

---
 rtl/mux_2to1.sv | 110 +++++++++++
 tb/tb_mux_2to1.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2to1.sv
// -----------------------------------------------------------------------------
// mux_2to1
//   Bit selector for the TRNG entropy path plus a clocked health monitor.
//
//   The selected bit Y is a pure combinational function of Select/I0/I1, so
//   the chosen oscillator's edges reach Y without ever touching a flop. The
//   rest of the block only observes the path:
//     - Y_q        : Y registered on clk
//     - sel_q      : Select after a SYNC_STAGES-flop synchroniser
//     - sel_change : one-cycle pulse in the cycle sel_q takes a new value
//     - toggle_cnt : saturating count of Y_q transitions, cleared whenever the
//                    selected source changes, so it always describes the
//                    source currently in use
//
// Parameters
//   SYNC_STAGES : flops in the Select synchroniser (must be >= 1)
//   CNT_W       : width of toggle_cnt
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   I0, I1     in   1      raw source bits, asynchronous to clk
//   Select     in   1      0 selects I0, 1 selects I1 (asynchronous to clk)
//   Y          out  1      combinational selected bit, valid during reset
//   Y_q        out  1      Y registered
//   sel_q      out  1      synchronised Select
//   sel_change out  1      registered select-change pulse
//   toggle_cnt out  CNT_W  Y_q transitions since the last clear
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mux_2to1 #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I0,
  input  logic             I1,
  input  logic             Select,
  output logic             Y,
  output logic             Y_q,
  output logic             sel_q,
  output logic             sel_change,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Increment that sticks at full scale instead of wrapping, so a source
  // that toggles for a long time reads as "busy" rather than a small count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Entropy path: no clock, no reset, zero latency.
  assign Y = Select ? I1 : I0;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [SYNC_STAGES-1:0] sync_nxt;
  logic                   y_p0;
  logic                   y_p1;
  logic                   sel_chg_d;
  logic                   toggle;
  logic [CNT_W-1:0]       cnt_p0;

  // Next state of the synchroniser chain: Select enters at bit 0 and every
  // flop takes its neighbour's value. Written as a shift so a single-stage
  // chain needs no special case.
  always_comb begin
    sync_nxt    = sync_p0 << 1;
    sync_nxt[0] = Select;
  end

  // The pulse is computed from the value sel_q is about to take, so once
  // registered it lines up with the cycle sel_q changes. The counter clear
  // uses the same unregistered term, making toggle_cnt read 0 in that cycle.
  assign sel_chg_d = sync_p0[SYNC_STAGES-1] ^ sync_nxt[SYNC_STAGES-1];

  // A transition is seen one cycle after it appears on Y_q.
  assign toggle = y_p0 ^ y_p1;

  // ---- stage p0: Y sample, synchroniser, pulse and counter ----
  // ---- stage p1: previous Y_q for transition detection ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0    <= '0;
      y_p0       <= 1'b0;
      y_p1       <= 1'b0;
      sel_change <= 1'b0;
      cnt_p0     <= '0;
    end else begin
      sync_p0    <= sync_nxt;
      y_p0       <= Y;
      y_p1       <= y_p0;
      sel_change <= sel_chg_d;
      // A source switch discards the old source's count, even if a
      // transition lands on the same edge.
      if (sel_chg_d) begin
        cnt_p0 <= '0;
      end else if (toggle) begin
        cnt_p0 <= sat_inc(cnt_p0);
      end
    end
  end

  assign Y_q        = y_p0;
  assign sel_q      = sync_p0[SYNC_STAGES-1];
  assign toggle_cnt = cnt_p0;

endmodule

// File: tb/tb_mux_2to1.sv
`timescale 1ns/1ps
module tb_mux_2to1;

  localparam int S     = 2;
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int HLEN  = 4096;

  logic          clk    = 1'b0;
  bit            clk_en = 1'b0;
  logic          rst    = 1'b0;
  logic          I0     = 1'b0;
  logic          I1     = 1'b0;
  logic          Select = 1'b0;
  logic          Y;
  logic          Y_q;
  logic          sel_q;
  logic          sel_change;
  logic [CW-1:0] toggle_cnt;

  int checks = 0;
  int errors = 0;

  mux_2to1 #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .I0        (I0),
    .I1        (I1),
    .Select    (Select),
    .Y         (Y),
    .Y_q       (Y_q),
    .sel_q     (sel_q),
    .sel_change(sel_change),
    .toggle_cnt(toggle_cnt)
  );

  // Clock only runs once the combinational-only tests are done.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Reference model: a history of what each edge sampled. Register outputs
  // are read back out of that history by position; anything at or before
  // the most recent reset edge counts as 0.
  bit ysamp [HLEN];
  bit ssamp [HLEN];
  int n      = 0;
  int base   = 0;
  int cnt_m  = 0;
  bit tog_m  = 1'b0;
  bit chg_m  = 1'b0;

  function automatic bit yq_at(input int k);
    return (k <= base) ? 1'b0 : ysamp[k];
  endfunction

  function automatic bit sq_at(input int k);
    return (k - S + 1 <= base) ? 1'b0 : ssamp[k - S + 1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    n++;
    if (n >= HLEN) begin
      $display("FAIL history_overflow observed=%0d expected<%0d", n, HLEN);
      $fatal(1, "model history exhausted");
    end
    if (rst) begin
      base  = n;
      cnt_m = 0;
      tog_m = 1'b0;
      chg_m = 1'b0;
    end else begin
      ysamp[n] = Select ? I1 : I0;
      ssamp[n] = Select;
      chg_m = (sq_at(n) != sq_at(n - 1));
      tog_m = (yq_at(n - 1) != yq_at(n - 2));
      if (chg_m)                      cnt_m = 0;
      else if (tog_m && cnt_m < CMAX) cnt_m = cnt_m + 1;
    end
  endtask

  task automatic check_all();
    chk("Y",          32'(Y),          32'(Select ? I1 : I0));
    chk("Y_q",        32'(Y_q),        32'(yq_at(n)));
    chk("sel_q",      32'(sel_q),      32'(sq_at(n)));
    chk("sel_change", 32'(sel_change), 32'(chg_m));
    chk("toggle_cnt", 32'(toggle_cnt), 32'(cnt_m));
  endtask

  // One clock: model follows the edge, outputs sampled 1ns later, and the
  // caller drives new inputs afterwards (well before the next edge).
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    bit found;
    bit e0, e1, es;

    // ---- combinational select, clock stopped ----
    Select = 1'b0; I0 = 1'b1; I1 = 1'b0; #1;
    chk("comb_sel0", 32'(Y), 32'd1);
    Select = 1'b1; I0 = 1'b0; I1 = 1'b1; #1;
    chk("comb_sel1", 32'(Y), 32'd1);
    I1 = 1'b0; #1;
    chk("comb_sel1_low", 32'(Y), 32'd0);

    // ---- free-running sources, no clock ----
    I0 = 1'b0; I1 = 1'b0; Select = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (t > 0) begin
        if (t % 2 == 0)  I0 = ~I0;
        if (t % 4 == 0)  I1 = ~I1;
        if (t % 20 == 0) Select = ~Select;
      end
      #0.5;
      e0 = ((t / 2) % 2) == 1;
      e1 = ((t / 4) % 2) == 1;
      es = ((t / 20) % 2) == 1;
      chk("freerun_Y", 32'(Y), 32'(es ? e1 : e0));
      #0.5;
    end

    // ---- reset behaviour ----
    clk_en = 1'b1;
    rst = 1'b1; I0 = 1'b1; I1 = 1'b0; Select = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_Y",   32'(Y),          32'd1);
      chk("rst_Yq",  32'(Y_q),        32'd0);
      chk("rst_selq",32'(sel_q),      32'd0);
      chk("rst_cnt", 32'(toggle_cnt), 32'd0);
      #3;
      chk("rst_Y_mid", 32'(Y), 32'd1);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_Yq", 32'(Y_q), 32'd1);
    chk("post_rst_chg", 32'(sel_change), 32'd0);

    // ---- synchroniser latency ----
    tick();
    Select = 1'b1;
    tick();
    chk("sync_n1_selq", 32'(sel_q),      32'd0);
    chk("sync_n1_chg",  32'(sel_change), 32'd0);
    tick();
    chk("sync_n2_selq", 32'(sel_q),      32'd1);
    chk("sync_n2_chg",  32'(sel_change), 32'd1);
    tick();
    chk("sync_n3_selq", 32'(sel_q),      32'd1);
    chk("sync_n3_chg",  32'(sel_change), 32'd0);

    // ---- saturation ----
    Select = 1'b0; I0 = 1'b0; I1 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_start", 32'(toggle_cnt), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      I0 = ~I0;
      tick();
      chk("sat_cnt", 32'(toggle_cnt), 32'((i - 1 > CMAX) ? CMAX : i - 1));
    end
    Select = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (sel_change === 1'b1) begin
        found = 1'b1;
        chk("sat_clear", 32'(toggle_cnt), 32'd0);
      end
    end
    chk("sat_pulse_seen", 32'(found), 32'd1);

    // ---- clear beats a simultaneous toggle ----
    I0 = 1'b0; I1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      I0 = ~I0; I1 = I0;
      tick();
    end
    Select = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      I0 = ~I0; I1 = I0;
      tick();
      if (sel_change === 1'b1) begin
        found = 1'b1;
        chk("prio_clear", 32'(toggle_cnt), 32'd0);
      end
    end
    chk("prio_pulse_seen", 32'(found), 32'd1);
    I0 = ~I0; I1 = I0;
    tick();
    chk("prio_next", 32'(toggle_cnt), 32'd1);

    // ---- randomized traffic with occasional resets ----
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      I0  = 1'($urandom);
      I1  = 1'($urandom);
      if ($urandom_range(0, 5) == 0) Select = ~Select;
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
